test_status_port: RTL and testbench
===================================

# test_status_port

Memory-mapped, self-checking test status peripheral on the SoC data bus. Assembly test programs store test IDs, expected values and actual values to it, and the block compares them in hardware. It tracks pass/fail, check counts and a watchdog. It is the responder side of the per-test checking that the bench otherwise does by probing x1/x29/x30/x31: the program reports its results, and the block judges them.

## Interface
Parameters:
- BASE_ADDR, 32'h8000_0000, word-aligned base address; decoded on bus_addr[31:5].
- TIMEOUT_CYCLES, 1024, cycles allowed between TEST_ID writes while RUNNING.
- CNT_WIDTH, 16, width of the check and pass counters.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- bus_addr  in  32  byte address from CPU.
- bus_wdata  in  32  store data.
- bus_we  in  1  word store strobe, sampled on the rising edge.
- bus_re  in  1  load strobe.
- bus_sel  out  1  combinational address hit.
- bus_rdata  out  32  combinational read data; 0 when not (bus_re && bus_sel).
- test_done  out  1  registered; 1 in PASSED or FAILED.
- test_pass  out  1  registered; 1 only in PASSED.
- test_fail  out  1  registered; 1 only in FAILED.
- fail_code  out  3  registered; 0 none, 1 mismatch, 2 test ID not increasing, 3 watchdog, 4 DONE with no test.
- fail_test_id  out  32  registered TEST_ID at the moment of failure.

## Operation
Register map, by offset bus_addr[4:2]; offsets 5–7 read 0 and ignore writes:
- 0 TEST_ID, R/W.
- 1 EXPECTED, R/W.
- 2 ACTUAL, R/W; a write triggers a compare.
- 3 CONTROL. A write of bit0=1 means DONE. Read returns {fail_code[6:4], state[1:0]}.
- 4 COUNTS, RO. Returns {pass_count, check_count}, each zero-extended or truncated to 16 bits.

State machine, 2-bit encoding IDLE=0, RUNNING=1, PASSED=2, FAILED=3:
- IDLE, TEST_ID write: go to RUNNING and latch the ID.
- IDLE, DONE write: go to FAILED with code 4.
- RUNNING, TEST_ID write:
  - If the value is greater than the current ID (unsigned), latch it and clear the watchdog.
  - Otherwise go to FAILED with code 2.
- RUNNING, ACTUAL write:
  - check_count always increments.
  - If wdata equals EXPECTED, pass_count increments.
  - Otherwise go to FAILED with code 1.
- RUNNING, DONE write: go to PASSED.
- RUNNING, watchdog reaches TIMEOUT_CYCLES-1 with no TEST_ID write: go to FAILED with code 3.
- PASSED and FAILED are terminal until reset. All writes are ignored in these states; reads still work.

Other rules:
- EXPECTED and ACTUAL are writable in IDLE. An ACTUAL write in IDLE stores the value only: no compare, no count.
- Counters saturate at all-ones.
- The watchdog counts only in RUNNING.
- fail_test_id captures the current TEST_ID register when entering FAILED. It is 0 for code 4.

## Timing
- Reset (async) values:
  - state IDLE; all registers, counters and the watchdog 0.
  - test_done, test_pass, test_fail 0; fail_code 0; fail_test_id 0.
  - bus_rdata 0.
- Writes and compares take effect on the edge where bus_we=1. The status outputs update on that same edge, so they are visible one cycle after the store is presented.
- Reads are zero-latency, combinational, and reflect pre-edge state. This makes them compatible with the single-cycle CPU load path.
- Only one bus access happens per cycle, so a write cannot collide with another write.
- If a TEST_ID write and watchdog expiry fall on the same edge, the write wins: the watchdog clears and no failure occurs.
- An ACTUAL write that mismatches increments check_count on the same edge it enters FAILED.
- Reset asserted mid-run returns everything to IDLE immediately, without waiting for a clock edge.

## Test plan
- Write TEST_ID=1, EXPECTED=5, ACTUAL=5, then CONTROL=1.
  - Required: PASSED, test_pass=1, COUNTS=0x0001_0001, fail_code=0.
- Write TEST_ID=3, EXPECTED=0xFF, ACTUAL=0xFE.
  - Required: on the next cycle test_fail=1, fail_code=1, fail_test_id=3, check_count=1, pass_count=0.
  - A later ACTUAL=0xFF write changes nothing.
- Write TEST_ID=4, then TEST_ID=2.
  - Required: FAILED, fail_code=2, fail_test_id=4.
- Run with TIMEOUT_CYCLES=8: write TEST_ID=1, then idle.
  - Required: FAILED with code 3 eight cycles after the write.
  - Repeat, with a TEST_ID=2 write landing exactly on the expiry edge. Required: still RUNNING, and the watchdog restarts.
- Write CONTROL=1 out of reset.
  - Required: FAILED, fail_code=4.
  - Read offset 3. Required: 0x43.
- Reset mid-run, after two passing checks.
  - Required: all outputs 0 before the next edge, and COUNTS reads 0.
  - Reads outside BASE_ADDR's 32-byte window. Required: bus_sel=0 and bus_rdata=0.

Source files
------------

// File: rtl/test_status_port.sv
// test_status_port
//
// Memory-mapped self-checking test status peripheral. An assembly test
// program stores test IDs, expected values and actual values into a 32-byte
// register window. The block compares them in hardware and tracks pass/fail,
// check counts and a watchdog. Once a verdict is reached (PASSED or FAILED)
// the block holds it until reset.
//
// Ports:
//   clk           single clock, all state updates on the rising edge
//   reset         asynchronous, active-high
//   bus_addr      byte address from the CPU; window decoded on [31:5]
//   bus_wdata     store data
//   bus_we        word store strobe, sampled on the rising edge
//   bus_re        load strobe
//   bus_sel       combinational address hit
//   bus_rdata     combinational read data, 0 unless bus_re && bus_sel
//   test_done     registered, 1 in PASSED or FAILED
//   test_pass     registered, 1 only in PASSED
//   test_fail     registered, 1 only in FAILED
//   fail_code     registered: 0 none, 1 mismatch, 2 ID not increasing,
//                 3 watchdog, 4 DONE with no test
//   fail_test_id  registered TEST_ID captured on entry to FAILED
//
// Register map (offset = bus_addr[4:2]):
//   0 TEST_ID  R/W   1 EXPECTED R/W   2 ACTUAL R/W (write compares)
//   3 CONTROL  W bit0=DONE, R {fail_code[6:4], state[1:0]}
//   4 COUNTS   RO {pass_count[15:0], check_count[15:0]}   5-7 read 0
module test_status_port #(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_re,
  output logic        bus_sel,
  output logic [31:0] bus_rdata,
  output logic        test_done,
  output logic        test_pass,
  output logic        test_fail,
  output logic [2:0]  fail_code,
  output logic [31:0] fail_test_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PASSED  = 2'd2,
    ST_FAILED  = 2'd3
  } state_t;

  // +1 keeps the width non-zero even for a one-cycle timeout
  localparam int                   WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]      WD_MAX  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  localparam logic [2:0] OFF_TEST_ID  = 3'd0;
  localparam logic [2:0] OFF_EXPECTED = 3'd1;
  localparam logic [2:0] OFF_ACTUAL   = 3'd2;
  localparam logic [2:0] OFF_CONTROL  = 3'd3;
  localparam logic [2:0] OFF_COUNTS   = 3'd4;

  localparam logic [2:0] FC_MISMATCH = 3'd1;
  localparam logic [2:0] FC_ID_ORDER = 3'd2;
  localparam logic [2:0] FC_WATCHDOG = 3'd3;
  localparam logic [2:0] FC_NO_TEST  = 3'd4;

  state_t                r_state;
  logic [31:0]           r_test_id;
  logic [31:0]           r_expected;
  logic [31:0]           r_actual;
  logic [CNT_WIDTH-1:0]  r_check_cnt;
  logic [CNT_WIDTH-1:0]  r_pass_cnt;
  logic [WD_W-1:0]       r_wd;

  logic        w_hit;
  logic [2:0]  w_off;
  logic        w_wr;
  logic        w_wr_id;
  logic        w_wr_exp;
  logic        w_wr_act;
  logic        w_wr_done;
  logic        w_act_match;
  logic        w_id_incr;
  logic [31:0] w_rdata;
  logic [1:0]  w_unused_addr;

  // Saturating increment: counters stick at all-ones
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Zero-extend or truncate a counter to the 16-bit COUNTS field
  function automatic logic [15:0] fit16(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH+15:0] ext;
    ext = {16'h0000, v};
    return ext[15:0];
  endfunction

  assign w_hit         = (bus_addr[31:5] == BASE_ADDR[31:5]);
  assign bus_sel       = w_hit;
  assign w_off         = bus_addr[4:2];
  assign w_unused_addr = bus_addr[1:0];
  assign w_wr          = bus_we && w_hit;
  assign w_wr_id       = w_wr && (w_off == OFF_TEST_ID);
  assign w_wr_exp      = w_wr && (w_off == OFF_EXPECTED);
  assign w_wr_act      = w_wr && (w_off == OFF_ACTUAL);
  assign w_wr_done     = w_wr && (w_off == OFF_CONTROL) && bus_wdata[0];
  assign w_act_match   = (bus_wdata == r_expected);
  assign w_id_incr     = (bus_wdata > r_test_id);

  // Test-status FSM with its registers, counters, watchdog and verdict outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_test_id    <= 32'h0;
      r_expected   <= 32'h0;
      r_actual     <= 32'h0;
      r_check_cnt  <= '0;
      r_pass_cnt   <= '0;
      r_wd         <= '0;
      test_done    <= 1'b0;
      test_pass    <= 1'b0;
      test_fail    <= 1'b0;
      fail_code    <= 3'd0;
      fail_test_id <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_id) begin
            r_test_id <= bus_wdata;
            r_wd      <= '0;
            r_state   <= ST_RUNNING;
          end else if (w_wr_done) begin
            r_state      <= ST_FAILED;
            test_done    <= 1'b1;
            test_fail    <= 1'b1;
            fail_code    <= FC_NO_TEST;
            fail_test_id <= 32'h0;
          end else begin
            // ACTUAL in IDLE is a plain store: no compare, no count
            if (w_wr_exp) r_expected <= bus_wdata;
            if (w_wr_act) r_actual <= bus_wdata;
          end
        end
        ST_RUNNING: begin
          // A TEST_ID write outranks a watchdog expiry on the same edge
          if (w_wr_id) begin
            if (w_id_incr) begin
              r_test_id <= bus_wdata;
              r_wd      <= '0;
            end else begin
              r_state      <= ST_FAILED;
              test_done    <= 1'b1;
              test_fail    <= 1'b1;
              fail_code    <= FC_ID_ORDER;
              fail_test_id <= r_test_id;
            end
          end else if (w_wr_done) begin
            r_state   <= ST_PASSED;
            test_done <= 1'b1;
            test_pass <= 1'b1;
          end else if (w_wr_act && !w_act_match) begin
            r_actual     <= bus_wdata;
            r_check_cnt  <= sat_inc(r_check_cnt);
            r_state      <= ST_FAILED;
            test_done    <= 1'b1;
            test_fail    <= 1'b1;
            fail_code    <= FC_MISMATCH;
            fail_test_id <= r_test_id;
          end else begin
            if (w_wr_exp) r_expected <= bus_wdata;
            if (w_wr_act) begin
              r_actual    <= bus_wdata;
              r_check_cnt <= sat_inc(r_check_cnt);
              r_pass_cnt  <= sat_inc(r_pass_cnt);
            end
            if (r_wd == WD_MAX) begin
              r_state      <= ST_FAILED;
              test_done    <= 1'b1;
              test_fail    <= 1'b1;
              fail_code    <= FC_WATCHDOG;
              fail_test_id <= r_test_id;
            end else begin
              r_wd <= r_wd + WD_W'(1);
            end
          end
        end
        ST_PASSED, ST_FAILED: begin
          // Verdict is held until reset; writes are ignored
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Zero-latency read mux reflecting pre-edge state
  always_comb begin
    w_rdata = 32'h0;
    if (bus_re && w_hit) begin
      case (w_off)
        OFF_TEST_ID:  w_rdata = r_test_id;
        OFF_EXPECTED: w_rdata = r_expected;
        OFF_ACTUAL:   w_rdata = r_actual;
        OFF_CONTROL:  w_rdata = {25'h0, fail_code, 2'b00, r_state};
        OFF_COUNTS:   w_rdata = {fit16(r_pass_cnt), fit16(r_check_cnt)};
        default:      w_rdata = 32'h0;
      endcase
    end else begin
      w_rdata = 32'h0;
    end
  end

  assign bus_rdata = w_rdata;

endmodule

// File: tb/tb_test_status_port.sv
// Scoreboard bench for test_status_port. The driver issues one bus access per
// cycle just after the rising edge, pushes what the DUT must show before the
// next edge (read data and status outputs) into a queue, then advances a
// behavioural model across the edge. A monitor on the falling edge pops and
// compares. The watchdog is shortened to 8 cycles.
module tb_test_status_port;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          TMO  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic        bus_sel;
  logic [31:0] bus_rdata;
  logic        test_done;
  logic        test_pass;
  logic        test_fail;
  logic [2:0]  fail_code;
  logic [31:0] fail_test_id;

  test_status_port #(
    .BASE_ADDR     (BASE),
    .TIMEOUT_CYCLES(TMO),
    .CNT_WIDTH     (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_we      (bus_we),
    .bus_re      (bus_re),
    .bus_sel     (bus_sel),
    .bus_rdata   (bus_rdata),
    .test_done   (test_done),
    .test_pass   (test_pass),
    .test_fail   (test_fail),
    .fail_code   (fail_code),
    .fail_test_id(fail_test_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sel;
    logic [31:0] rdata;
    logic        done;
    logic        pass;
    logic        fail;
    logic [2:0]  code;
    logic [31:0] fid;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: 0 idle, 1 running, 2 passed, 3 failed
  int          m_state;
  logic [31:0] m_id, m_exp, m_act, m_fid;
  int          m_chk, m_pas, m_since, m_code;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'd32);
  endfunction

  function automatic int off_of(input logic [31:0] a);
    return int'((a - BASE) / 32'd4);
  endfunction

  function automatic void m_reset();
    m_state = 0; m_id = 32'h0; m_exp = 32'h0; m_act = 32'h0; m_fid = 32'h0;
    m_chk = 0; m_pas = 0; m_since = 0; m_code = 0;
  endfunction

  function automatic void m_fail(input int code);
    m_fid   = (code == 4) ? 32'h0 : m_id;
    m_code  = code;
    m_state = 3;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [31:0] m_read(input int off);
    case (off)
      0:       return m_id;
      1:       return m_exp;
      2:       return m_act;
      3:       return 32'(m_code * 16 + m_state);
      4:       return 32'(longint'(m_pas) * 65536 + longint'(m_chk));
      default: return 32'h0;
    endcase
  endfunction

  // Effect of one rising edge on the model
  function automatic void m_edge(input bit wr, input int off, input logic [31:0] d);
    if (m_state == 0) begin
      if (wr && off == 0) begin m_id = d; m_state = 1; m_since = 0; end
      else if (wr && off == 1) m_exp = d;
      else if (wr && off == 2) m_act = d;
      else if (wr && off == 3 && d[0]) m_fail(4);
    end else if (m_state == 1) begin
      if (wr && off == 0) begin
        if (d > m_id) begin m_id = d; m_since = 0; end
        else m_fail(2);
      end else if (wr && off == 3 && d[0]) begin
        m_state = 2;
      end else begin
        if (wr && off == 1) m_exp = d;
        if (wr && off == 2) begin
          m_act = d;
          m_chk = sat16(m_chk + 1);
          if (d == m_exp) m_pas = sat16(m_pas + 1);
          else m_fail(1);
        end
        if (m_state == 1) begin
          m_since++;
          if (m_since == TMO) m_fail(3);
        end
      end
    end
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endfunction

  // Monitor: compare the DUT against the oldest pending expectation
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk({mon_e.name, "/bus_sel"},   32'(bus_sel),   32'(mon_e.sel));
      chk({mon_e.name, "/bus_rdata"}, bus_rdata,      mon_e.rdata);
      chk({mon_e.name, "/test_done"}, 32'(test_done), 32'(mon_e.done));
      chk({mon_e.name, "/test_pass"}, 32'(test_pass), 32'(mon_e.pass));
      chk({mon_e.name, "/test_fail"}, 32'(test_fail), 32'(mon_e.fail));
      chk({mon_e.name, "/fail_code"}, 32'(fail_code), 32'(mon_e.code));
      chk({mon_e.name, "/fail_id"},   fail_test_id,   mon_e.fid);
    end
  end

  // One bus cycle; entered and left just after a rising edge
  task automatic cyc(input string nm, input bit we, input bit re, input logic [31:0] a,
                     input logic [31:0] d, input bit rst, input bit use_c, input logic [31:0] c);
    exp_t e;
    bus_we = we; bus_re = re; bus_addr = a; bus_wdata = d;
    if (rst) begin
      reset = 1'b1;
      m_reset();
    end
    e.name  = nm;
    e.sel   = in_win(a);
    e.rdata = use_c ? c : ((re && in_win(a)) ? m_read(off_of(a)) : 32'h0);
    e.done  = (m_state >= 2);
    e.pass  = (m_state == 2);
    e.fail  = (m_state == 3);
    e.code  = 3'(m_code);
    e.fid   = m_fid;
    sb.push_back(e);
    @(posedge clk);
    if (!rst) m_edge(we && in_win(a), in_win(a) ? off_of(a) : 0, d);
    #1;
    reset = 1'b0;
  endtask

  task automatic wr(input string nm, input int off, input logic [31:0] d);
    cyc(nm, 1'b1, 1'b0, BASE + 32'(off * 4), d, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd(input string nm, input int off, input logic [31:0] c);
    cyc(nm, 1'b0, 1'b1, BASE + 32'(off * 4), 32'h0, 1'b0, 1'b1, c);
  endtask

  task automatic idle(input string nm);
    cyc(nm, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rst_cyc(input string nm);
    cyc(nm, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; bus_we = 1'b0; bus_re = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
    m_reset();
    @(posedge clk);
    #1;
    rst_cyc("reset");
    rd("reset_counts", 4, 32'h0);

    // Passing test
    wr("t1_id", 0, 32'd1); wr("t1_exp", 1, 32'd5); wr("t1_act", 2, 32'd5); wr("t1_done", 3, 32'd1);
    rd("t1_counts", 4, 32'h0001_0001);
    rd("t1_ctrl", 3, 32'h02);

    // Mismatch, then later writes ignored
    rst_cyc("t2_rst");
    wr("t2_id", 0, 32'd3); wr("t2_exp", 1, 32'hFF); wr("t2_act", 2, 32'hFE);
    rd("t2_counts", 4, 32'h0000_0001);
    wr("t2_act2", 2, 32'hFF);
    rd("t2_actual", 2, 32'hFE);
    rd("t2_counts2", 4, 32'h0000_0001);
    rd("t2_ctrl", 3, 32'h13);

    // Non-increasing test ID
    rst_cyc("t3_rst");
    wr("t3_id4", 0, 32'd4); wr("t3_id2", 0, 32'd2);
    rd("t3_ctrl", 3, 32'h23);
    rd("t3_id", 0, 32'd4);

    // Watchdog expiry eight edges after the TEST_ID write
    rst_cyc("t4_rst");
    wr("t4_id", 0, 32'd1);
    repeat (7) idle("t4_idle");
    rd("t4_ctrl_run", 3, 32'h01);
    rd("t4_ctrl_wd", 3, 32'h33);

    // TEST_ID write on the expiry edge wins and restarts the watchdog
    rst_cyc("t4b_rst");
    wr("t4b_id1", 0, 32'd1);
    repeat (7) idle("t4b_idle");
    wr("t4b_id2", 0, 32'd2);
    rd("t4b_ctrl_run", 3, 32'h01);
    repeat (6) idle("t4b_idle2");
    rd("t4b_ctrl_run2", 3, 32'h01);
    rd("t4b_ctrl_wd", 3, 32'h33);
    rd("t4b_id", 0, 32'd2);

    // DONE out of reset
    rst_cyc("t5_rst");
    wr("t5_done", 3, 32'd1);
    rd("t5_ctrl", 3, 32'h43);
    rd("t5_id", 0, 32'h0);

    // Reset mid-run after two passing checks, then out-of-window reads
    rst_cyc("t6_rst");
    wr("t6_id", 0, 32'd1); wr("t6_exp", 1, 32'd7); wr("t6_act", 2, 32'd7); wr("t6_act2", 2, 32'd7);
    rd("t6_counts", 4, 32'h0002_0002);
    cyc("t6_async_rst", 1'b0, 1'b1, BASE + 32'd16, 32'h0, 1'b1, 1'b1, 32'h0);
    rd("t6_counts_after", 4, 32'h0);
    cyc("t6_oow_hi", 1'b0, 1'b1, BASE + 32'd32, 32'h0, 1'b0, 1'b1, 32'h0);
    cyc("t6_oow_lo", 1'b0, 1'b1, BASE - 32'd4, 32'h0, 1'b0, 1'b1, 32'h0);
    cyc("t6_oow_zero", 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);

    // Randomized runs against the model
    for (int r = 0; r < 25; r++) begin
      rst_cyc("rnd_rst");
      for (int k = 0; k < 40; k++) begin
        int          p;
        logic [31:0] v;
        logic [31:0] a;
        p = int'($urandom_range(0, 99));
        if (p < 15) begin
          v = m_id + 32'($urandom_range(0, 3));
          if ($urandom_range(0, 9) == 0) v = $urandom;
          wr("rnd_id", 0, v);
        end else if (p < 30) begin
          wr("rnd_exp", 1, 32'($urandom_range(0, 3)));
        end else if (p < 48) begin
          v = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : m_exp;
          wr("rnd_act", 2, v);
        end else if (p < 51) begin
          wr("rnd_ctrl", 3, 32'($urandom_range(0, 1)));
        end else if (p < 75) begin
          cyc("rnd_rd", 1'b0, 1'b1, BASE + 32'(4 * $urandom_range(0, 7)), 32'h0, 1'b0, 1'b0, 32'h0);
        end else if (p < 82) begin
          a = ($urandom_range(0, 1) == 1) ? (BASE - 32'(4 * $urandom_range(1, 8)))
                                          : (BASE + 32'd32 + 32'(4 * $urandom_range(0, 7)));
          cyc("rnd_oow", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
              1'b0, 1'b0, 32'h0);
        end else if (p < 86) begin
          cyc("rnd_hi_off", 1'b1, 1'b0, BASE + 32'(4 * $urandom_range(4, 7)), $urandom,
              1'b0, 1'b0, 32'h0);
        end else begin
          idle("rnd_idle");
        end
      end
      rd("rnd_counts", 4, m_read(4));
    end

    idle("drain");
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
